// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller.
//   - register index constants for the 16-entry port window
//   - bit position of the VECTOR valid flag
//   - widest supported line count and a helper that builds the mask of
//     implemented lines for a given NUM_LINES
package irq_pkg;

    localparam int MAX_LINES = 16;

    localparam logic [3:0] IRQ_PEND_LO = 4'd0;
    localparam logic [3:0] IRQ_PEND_HI = 4'd1;
    localparam logic [3:0] IRQ_MASK_LO = 4'd2;
    localparam logic [3:0] IRQ_MASK_HI = 4'd3;
    localparam logic [3:0] IRQ_MODE_LO = 4'd4;
    localparam logic [3:0] IRQ_MODE_HI = 4'd5;
    localparam logic [3:0] IRQ_VECTOR  = 4'd6;
    localparam logic [3:0] IRQ_CTRL    = 4'd7;

    localparam int IRQ_VALID_BIT = 7;

    // Result of the priority encoder: lowest pending unmasked line.
    typedef struct packed {
        logic       valid;
        logic [3:0] idx;
    } irq_vec_t;

    // One bit per implemented line; bits at or above n are zero.
    function automatic logic [MAX_LINES-1:0] line_mask(input int n);
        logic [MAX_LINES-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_LINES; i++) begin
            if (i < n) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/irq_line_sync.sv
// Per-line input conditioning for one asynchronous interrupt request.
//   clk_i   : IO bus clock
//   reset_i : synchronous active-high reset
//   irq_i   : raw request, asynchronous to clk_i
//   s2      : synchronised level (second synchroniser flop)
//   rise    : one-cycle pulse when the synchronised level goes 0 -> 1
module irq_line_sync (
    input  logic clk_i,
    input  logic reset_i,
    input  logic irq_i,
    output logic s2,
    output logic rise
);

    logic s1;
    logic s3;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= irq_i;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // s3 holds the previous synchronised level, so this fires for one cycle.
    assign rise = s2 & ~s3;

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller on a 16-register IO port window.
// Each line has a mask bit and an edge/level mode bit. Edge events are
// latched until cleared by a write-1-to-clear or by reading VECTOR.
//   clk_i     : IO bus clock, rising edge
//   reset_i   : synchronous active-high reset
//   rd_i/wr_i : one-cycle read / write strobes for this window
//   A_i       : register index
//   D_i       : write data
//   D_o       : registered read data, holds when rd_i is low
//   irq_i     : raw interrupt requests (NUM_LINES wide)
//   n_int_o   : registered active-low CPU interrupt
module irq_controller
    import irq_pkg::*;
#(
    parameter int NUM_LINES = 8
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 rd_i,
    input  logic                 wr_i,
    input  logic [3:0]           A_i,
    input  logic [7:0]           D_i,
    output logic [7:0]           D_o,
    input  logic [NUM_LINES-1:0] irq_i,
    output logic                 n_int_o
);

    localparam logic [MAX_LINES-1:0] IMPL = line_mask(NUM_LINES);

    logic [MAX_LINES-1:0] s2_v;
    logic [MAX_LINES-1:0] rise_v;
    logic [MAX_LINES-1:0] pend_q;
    logic [MAX_LINES-1:0] mask_q;
    logic [MAX_LINES-1:0] mode_q;
    logic                 en_q;

    logic [MAX_LINES-1:0] active;
    irq_vec_t             vec;
    logic [7:0]           rd_data;
    logic [MAX_LINES-1:0] clr_w1c;
    logic [MAX_LINES-1:0] clr_ack;
    logic [MAX_LINES-1:0] clr;
    logic [MAX_LINES-1:0] pend_next;

    // Unimplemented lines are tied low so the rest of the logic can
    // always work on the full 16-bit width.
    genvar g;
    for (g = 0; g < MAX_LINES; g++) begin : g_line
        if (g < NUM_LINES) begin : g_impl
            irq_line_sync u_sync (
                .clk_i   (clk_i),
                .reset_i (reset_i),
                .irq_i   (irq_i[g]),
                .s2      (s2_v[g]),
                .rise    (rise_v[g])
            );
        end else begin : g_pad
            assign s2_v[g]   = 1'b0;
            assign rise_v[g] = 1'b0;
        end
    end

    // Lowest-numbered request wins.
    function automatic irq_vec_t prio_enc(input logic [MAX_LINES-1:0] req);
        irq_vec_t v;
        v = '0;
        for (int i = MAX_LINES - 1; i >= 0; i--) begin
            if (req[i]) begin
                v.valid = 1'b1;
                v.idx   = 4'(i);
            end
        end
        return v;
    endfunction

    assign active = pend_q & mask_q;
    assign vec    = prio_enc(active);

    always_comb begin
        rd_data = 8'h00;
        case (A_i)
            IRQ_PEND_LO: rd_data = active[7:0];
            IRQ_PEND_HI: rd_data = active[15:8];
            IRQ_MASK_LO: rd_data = mask_q[7:0];
            IRQ_MASK_HI: rd_data = mask_q[15:8];
            IRQ_MODE_LO: rd_data = mode_q[7:0];
            IRQ_MODE_HI: rd_data = mode_q[15:8];
            IRQ_VECTOR: begin
                rd_data[IRQ_VALID_BIT] = vec.valid;
                rd_data[3:0]           = vec.idx;
            end
            IRQ_CTRL:    rd_data[0] = en_q;
            default:     rd_data = 8'h00;
        endcase
    end

    always_comb begin
        clr_w1c = '0;
        if (wr_i && A_i == IRQ_PEND_LO) clr_w1c[7:0]  = D_i;
        if (wr_i && A_i == IRQ_PEND_HI) clr_w1c[15:8] = D_i;
    end

    // A VECTOR read acknowledges the line it reports.
    assign clr_ack = (rd_i && A_i == IRQ_VECTOR && vec.valid)
                     ? (16'd1 << vec.idx) : '0;

    // Clears only affect edge-mode lines; OR-ing rise last makes set win.
    assign clr       = (clr_w1c | clr_ack) & mode_q;
    assign pend_next = ((mode_q & ((pend_q & ~clr) | rise_v)) |
                        (~mode_q & s2_v)) & IMPL;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pend_q  <= '0;
            mask_q  <= '0;
            mode_q  <= '0;
            en_q    <= 1'b0;
            D_o     <= 8'h00;
            n_int_o <= 1'b1;
        end else begin
            pend_q  <= pend_next;
            n_int_o <= ~(en_q & |active);
            if (rd_i) D_o <= rd_data;
            if (wr_i) begin
                case (A_i)
                    IRQ_MASK_LO: mask_q[7:0]  <= D_i & IMPL[7:0];
                    IRQ_MASK_HI: mask_q[15:8] <= D_i & IMPL[15:8];
                    IRQ_MODE_LO: mode_q[7:0]  <= D_i & IMPL[7:0];
                    IRQ_MODE_HI: mode_q[15:8] <= D_i & IMPL[15:8];
                    IRQ_CTRL:    en_q         <= D_i[0];
                    default:     ;
                endcase
            end
        end
    end

endmodule
